pll_lock_supervisor: RTL and testbench

Sequences the clock-generation PLL at power-up and during operation. It holds the PLL in reset for a fixed interval, releases it, and waits for a synchronized, debounced LOCKED. Only then does it release the downstream system reset (ADC capture and FT245 FIFO logic). It retries on lock timeout, declares FAULT after a retry budget is spent, and re-sequences on loss of lock. It runs on the free-running board oscillator clock, never on the PLL output.

---
 rtl/pll_sup_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_lock_supervisor.sv | 162 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_e;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs (PLL lock, ADC/FT245 flags).
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset/lock and gates the downstream system reset on a stable lock.
// Runs from the free-running oscillator, never from the PLL output.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               clr_fault_i,
    input  logic               locked_i,
    output logic               pll_reset_o,
    output logic               sys_rst_n_o,
    output logic               ready_o,
    output logic               fault_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [LOSS_W-1:0]  loss_cnt_o
);

    localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    logic               lock_s;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               fail_c;
    logic               pll_reset_q, sys_rst_n_q, ready_q, fault_q;

    sync_2ff #(
        .W (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (locked_i),
        .q_o   (lock_s)
    );

    // Next-state, shared counter and statistics
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        fail_c  = 1'b0;

        case (state_q)
            HOLD: begin
                if (cnt_q == RST_LAST) begin
                    if (en_i) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (!en_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    fail_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!en_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (!lock_s) begin
                    fail_c = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                retry_d = '0;
                if (!en_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (!lock_s) begin
                    if (loss_q != {LOSS_W{1'b1}}) begin
                        loss_d = loss_q + LOSS_W'(1);
                    end
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            FAULT: begin
                if (clr_fault_i) begin
                    state_d = HOLD;
                    retry_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase

        // A failed attempt either retries from HOLD or gives up once the budget is spent
        if (fail_c) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
                state_d = FAULT;
            end else begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = HOLD;
            end
        end
    end

    // State, counters and outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= (state_d == HOLD) || (state_d == FAULT);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign sys_rst_n_o = sys_rst_n_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign retry_cnt_o = retry_q;
    assign loss_cnt_o  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed, self-checking bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr_fault;
    logic       locked;
    logic       pll_reset_o;
    logic       sys_rst_n_o;
    logic       ready_o;
    logic       fault_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .clr_fault_i (clr_fault),
        .locked_i    (locked),
        .pll_reset_o (pll_reset_o),
        .sys_rst_n_o (sys_rst_n_o),
        .ready_o     (ready_o),
        .fault_o     (fault_o),
        .retry_cnt_o (retry_cnt_o),
        .loss_cnt_o  (loss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; locked = 1'b0; clr_fault = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({pll_reset_o, sys_rst_n_o, ready_o, fault_o, retry_cnt_o, loss_cnt_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b",
                     {pll_reset_o, sys_rst_n_o, ready_o, fault_o, retry_cnt_o, loss_cnt_o},
                     {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        int n;
        n = 0;
        while (pll_reset_o === 1'b1 && n < 20) begin step(); n++; end
        n_tests++;
        if (n !== 4) begin n_fail++; $display("FAIL nominal_pll_reset_width: got %0d expected 4", n); end
        repeat (10) step();
        locked = 1'b1;
        n = 0;
        while (sys_rst_n_o !== 1'b1 && n < 40) begin step(); n++; end
        n_tests++;
        if (n !== 11) begin n_fail++; $display("FAIL nominal_lock_to_sysrst: got %0d expected 11", n); end
        n_tests++;
        if ({ready_o, pll_reset_o, fault_o, retry_cnt_o} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL nominal_run_outputs: got %b expected %b", {ready_o, pll_reset_o, fault_o, retry_cnt_o}, 7'b1000000);
        end
    endtask

    task automatic test_loss_in_run();
        int n;
        locked = 1'b0;
        step(); step();
        n_tests++;
        if (sys_rst_n_o !== 1'b1) begin n_fail++; $display("FAIL loss_early_sysrst: got %b expected 1", sys_rst_n_o); end
        step();
        n_tests++;
        if ({sys_rst_n_o, pll_reset_o, ready_o, loss_cnt_o} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL loss_third_edge: got %b expected %b", {sys_rst_n_o, pll_reset_o, ready_o, loss_cnt_o}, {3'b010, 8'd1});
        end
        locked = 1'b1;
        n = 0;
        while (ready_o !== 1'b1 && n < 60) begin step(); n++; end
        n_tests++;
        if (n !== 13 || loss_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL loss_resequence: got %0d cycles loss %0d expected 13 cycles loss 1", n, loss_cnt_o);
        end
    endtask

    task automatic test_en_in_run();
        en = 1'b0; locked = 1'b0;
        step();
        n_tests++;
        if ({sys_rst_n_o, pll_reset_o, ready_o, loss_cnt_o} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL en_off_run: got %b expected %b", {sys_rst_n_o, pll_reset_o, ready_o, loss_cnt_o}, {3'b010, 8'd1});
        end
        repeat (10) step();
        n_tests++;
        if (pll_reset_o !== 1'b1) begin n_fail++; $display("FAIL en_off_extends_reset: got %b expected 1", pll_reset_o); end
    endtask

    task automatic test_glitch_stable();
        int n;
        en = 1'b1;
        step();
        n_tests++;
        if (pll_reset_o !== 1'b0) begin n_fail++; $display("FAIL glitch_enter_wait: got %b expected 0", pll_reset_o); end
        locked = 1'b1;
        repeat (5) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        n = 0;
        while (pll_reset_o !== 1'b1 && n < 20) begin step(); n++; end
        n_tests++;
        if (n !== 2 || retry_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL glitch_fail: got %0d cycles retry %0d expected 2 cycles retry 1", n, retry_cnt_o);
        end
        n = 0;
        while (pll_reset_o === 1'b1 && n < 20) begin step(); n++; end
        n_tests++;
        if (n !== 4) begin n_fail++; $display("FAIL glitch_reset_width: got %0d expected 4", n); end
        n = 0;
        while (ready_o !== 1'b1 && n < 40) begin step(); n++; end
        n_tests++;
        if (n !== 9 || retry_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL glitch_second_run: got %0d cycles retry %0d expected 9 cycles retry 1", n, retry_cnt_o);
        end
        step();
        n_tests++;
        if (retry_cnt_o !== 4'd0) begin n_fail++; $display("FAIL glitch_retry_clear: got %0d expected 0", retry_cnt_o); end
    endtask

    task automatic test_timeout_fault();
        int n;
        en = 1'b0; locked = 1'b0;
        repeat (4) step();
        en = 1'b1;
        for (int a = 0; a < 3; a++) begin
            n = 0;
            while (pll_reset_o === 1'b1 && n < 40) begin step(); n++; end
            if (a > 0) begin
                n_tests++;
                if (n !== 4) begin n_fail++; $display("FAIL timeout_reset_width_%0d: got %0d expected 4", a, n); end
            end
            n = 0;
            while (pll_reset_o === 1'b0 && n < 40) begin step(); n++; end
            n_tests++;
            if (n !== 20) begin n_fail++; $display("FAIL timeout_low_width_%0d: got %0d expected 20", a, n); end
            n_tests++;
            if (a < 2) begin
                if ({fault_o, retry_cnt_o} !== {1'b0, 4'(a + 1)}) begin
                    n_fail++;
                    $display("FAIL timeout_retry_%0d: got fault %b retry %0d expected fault 0 retry %0d", a, fault_o, retry_cnt_o, a + 1);
                end
            end else if ({fault_o, pll_reset_o, sys_rst_n_o, retry_cnt_o} !== {3'b110, 4'd2}) begin
                n_fail++;
                $display("FAIL timeout_fault: got %b expected %b", {fault_o, pll_reset_o, sys_rst_n_o, retry_cnt_o}, 7'b1100010);
            end
        end
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (2) step();
        n_tests++;
        if ({fault_o, pll_reset_o} !== 2'b11) begin n_fail++; $display("FAIL fault_ignores_en: got %b expected 11", {fault_o, pll_reset_o}); end
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        n_tests++;
        if ({fault_o, pll_reset_o, sys_rst_n_o, retry_cnt_o} !== {3'b010, 4'd0}) begin
            n_fail++;
            $display("FAIL clr_fault: got %b expected %b", {fault_o, pll_reset_o, sys_rst_n_o, retry_cnt_o}, 7'b0100000);
        end
    endtask

    task automatic test_en_wait();
        int n;
        n = 0;
        while (pll_reset_o === 1'b1 && n < 40) begin step(); n++; end
        n = 0;
        while (pll_reset_o === 1'b0 && n < 40) begin step(); n++; end
        n = 0;
        while (pll_reset_o === 1'b1 && n < 40) begin step(); n++; end
        n_tests++;
        if (retry_cnt_o !== 4'd1) begin n_fail++; $display("FAIL en_wait_setup_retry: got %0d expected 1", retry_cnt_o); end
        repeat (5) step();
        en = 1'b0;
        step();
        n_tests++;
        if ({pll_reset_o, retry_cnt_o} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL en_off_wait: got reset %b retry %0d expected reset 1 retry 1", pll_reset_o, retry_cnt_o);
        end
        repeat (30) step();
        n_tests++;
        if ({pll_reset_o, fault_o, retry_cnt_o} !== {2'b10, 4'd1}) begin
            n_fail++;
            $display("FAIL en_off_hold: got %b expected %b", {pll_reset_o, fault_o, retry_cnt_o}, 6'b100001);
        end
        en = 1'b1; locked = 1'b1;
        n = 0;
        while (ready_o !== 1'b1 && n < 60) begin step(); n++; end
        n_tests++;
        if (n !== 11) begin n_fail++; $display("FAIL en_on_to_run: got %0d expected 11", n); end
        step();
    endtask

    task automatic test_back_to_back_losses();
        int n;
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            step();
            locked = 1'b1;
            step(); step();
            if (ready_o !== 1'b0) bad++;
            n = 0;
            while (ready_o !== 1'b1 && n < 40) begin step(); n++; end
            if (n !== 13) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL loss_loop_resequence: got %0d bad iterations expected 0", bad); end
        n_tests++;
        if (loss_cnt_o !== 8'd255) begin n_fail++; $display("FAIL loss_saturate: got %0d expected 255", loss_cnt_o); end
    endtask

    task automatic test_reset_mid_stable();
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (5) step();
        n_tests++;
        if ({pll_reset_o, sys_rst_n_o, ready_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_stable_setup: got %b expected 000", {pll_reset_o, sys_rst_n_o, ready_o});
        end
        #2;
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({pll_reset_o, sys_rst_n_o, ready_o, fault_o, retry_cnt_o, loss_cnt_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b",
                     {pll_reset_o, sys_rst_n_o, ready_o, fault_o, retry_cnt_o, loss_cnt_o},
                     {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_loss_in_run();
        test_en_in_run();
        test_glitch_stable();
        test_timeout_fault();
        test_en_wait();
        test_back_to_back_losses();
        test_reset_mid_stable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
